alu_pipe: RTL

Parametrised, registered ALU with valid/ready handshakes on input and output, status flags, barrel shifts and an optional iterative multiplier. It keeps the existing 4-bit opcode map and adds shift and multiply codes. It sits between the decode/operand-fetch stage and writeback in the core datapath, and stalls upstream through `in_ready` while a multiply is in flight.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_seq.sv | 71 +++++++
 rtl/alu_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode map, control states and status flags.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_INC = 4'b0010,
        OP_DEC = 4'b0011,
        OP_ADD = 4'b0100,
        OP_SUB = 4'b0101,
        OP_MUL = 4'b0110,
        OP_OR  = 4'b1000,
        OP_AND = 4'b1001,
        OP_XOR = 4'b1010,
        OP_NOT = 4'b1011,
        OP_SHL = 4'b1100,
        OP_SHR = 4'b1101,
        OP_SRA = 4'b1110
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] prod_lo_c,
    output logic [WIDTH-1:0] prod_hi_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_step_c;
    logic [WIDTH:0]   part_c;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        part_c     = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step_c = {part_c, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        done_c  = 1'b0;
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            mcand_d = a;
            acc_d   = {{WIDTH{1'b0}}, b};
        end else if (busy_q) begin
            acc_d = acc_step_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                done_c = 1'b1;
            end
        end
    end

    // The product is taken from the final step so it loads on the last iteration edge.
    assign prod_lo_c = acc_step_c[WIDTH-1:0];
    assign prod_hi_c = acc_step_c[ACC_W-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides, status flags and barrel shifts.
// Define ALU_PIPE_MUL_EN to add the iterative multiplier on opcode 0110.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned EXT_W = WIDTH + 1;

    alu_op_e          op_c;
    logic [WIDTH-1:0] add_b_c;
    logic             add_cin_c;
    logic [EXT_W-1:0] add_sum_c;
    logic [EXT_W-1:0] shl_ext_c;
    logic [EXT_W-1:0] shr_ext_c;
    logic [EXT_W-1:0] sra_ext_c;
    logic [SH_W-1:0]  sh_amt_c;
    logic [WIDTH-1:0] alu_res_c;
    alu_flags_t       alu_flags_c;
    logic             idle_c;
    logic             accept_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    alu_flags_t       flags_q, flags_d;

    assign op_c     = alu_op_e'(opcode);
    assign sh_amt_c = input_b[SH_W-1:0];

    // Single-cycle datapath; shifts carry one extra bit that catches the last bit shifted out.
    always_comb begin
        add_b_c   = input_b;
        add_cin_c = 1'b0;
        case (op_c)
            OP_INC:  add_b_c = WIDTH'(1);
            OP_DEC:  begin add_b_c = ~WIDTH'(1); add_cin_c = 1'b1; end
            OP_SUB:  begin add_b_c = ~input_b;   add_cin_c = 1'b1; end
            default: ;
        endcase
        add_sum_c = {1'b0, input_a} + {1'b0, add_b_c} + EXT_W'(add_cin_c);
        shl_ext_c = {1'b0, input_a} << sh_amt_c;
        shr_ext_c = {input_a, 1'b0} >> sh_amt_c;
        sra_ext_c = $signed({input_a, 1'b0}) >>> sh_amt_c;

        alu_res_c   = '0;
        alu_flags_c = '0;
        case (op_c)
            OP_NOP: alu_res_c = input_a;
            OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
                alu_res_c     = add_sum_c[WIDTH-1:0];
                alu_flags_c.c = add_sum_c[WIDTH];
                alu_flags_c.v = (input_a[WIDTH-1] == add_b_c[WIDTH-1]) &&
                                (add_sum_c[WIDTH-1] != input_a[WIDTH-1]);
            end
            OP_OR:  alu_res_c = input_a | input_b;
            OP_AND: alu_res_c = input_a & input_b;
            OP_XOR: alu_res_c = input_a ^ input_b;
            OP_NOT: alu_res_c = ~input_a;
            OP_SHL: begin
                alu_res_c     = shl_ext_c[WIDTH-1:0];
                alu_flags_c.c = shl_ext_c[WIDTH];
            end
            OP_SHR: begin
                alu_res_c     = shr_ext_c[WIDTH:1];
                alu_flags_c.c = shr_ext_c[0];
            end
            OP_SRA: begin
                alu_res_c     = sra_ext_c[WIDTH:1];
                alu_flags_c.c = sra_ext_c[0];
            end
            default: ;
        endcase
        alu_flags_c.z = (alu_res_c == '0);
        alu_flags_c.n = alu_res_c[WIDTH-1];
    end

    assign in_ready = idle_c && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    alu_state_e       state_q, state_d;
    logic             mul_start_c;
    logic             mul_done_c;
    logic [WIDTH-1:0] prod_lo_c;
    logic [WIDTH-1:0] prod_hi_c;

    assign idle_c = (state_q == ST_IDLE);

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mul_start_c),
        .a        (input_a),
        .b        (input_b),
        .done_c   (mul_done_c),
        .prod_lo_c(prod_lo_c),
        .prod_hi_c(prod_hi_c)
    );

    always_comb begin
        state_d     = state_q;
        mul_start_c = 1'b0;
        out_valid_d = out_valid_q && !out_ready;
        res_d       = res_q;
        flags_d     = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (op_c == OP_MUL) begin
                        state_d     = ST_MUL;
                        mul_start_c = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = alu_res_c;
                        flags_d     = alu_flags_c;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    res_d       = prod_lo_c;
                    flags_d.z   = (prod_lo_c == '0);
                    flags_d.n   = prod_lo_c[WIDTH-1];
                    flags_d.c   = |prod_hi_c;
                    flags_d.v   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end
`else
    assign idle_c = 1'b1;

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        res_d       = res_q;
        flags_d     = flags_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            res_d       = alu_res_c;
            flags_d     = alu_flags_c;
        end
    end
`endif

    // Output register: holds while the consumer stalls, refills on drain with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;

endmodule
